systolic_drain: RTL and testbench

South-edge collector for the int8 weight-stationary systolic array. It samples the 32-bit partial sums leaving the bottom row of PEs and removes the per-column diagonal skew, so each activation vector yields one aligned result row. Aligned rows are buffered in a FIFO and delivered to the downstream consumer over a valid/ready handshake. It is the receiving end of the array's south-flowing psum interface; the west-edge feeder is its counterpart on input.

---
 rtl/systolic_drain.sv | 114 +++++++++++
 tb/tb_systolic_drain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - south-edge psum collector: deskews bottom-row lanes into aligned rows and buffers them in a FIFO
module systolic_drain #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [COLS*32-1:0]       i_south,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [COLS*32-1:0]       o_data,
  output logic                     o_overflow,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int N  = ROWS + COLS - 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N:1]           v;
  logic [COLS*32-1:0]   row;
  logic [COLS*32-1:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        rd_next;
  logic [CW-1:0]        count_next;
  logic [COLS*32-1:0]   head_next;
  logic                 push;
  logic                 pop;
  logic                 accept;

  // v[k] marks a vector whose i_valid was k cycles ago
  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
    end else begin
      v[1] <= i_valid;
      for (int k = 2; k <= N; k++) begin
        v[k] <= v[k-1];
      end
    end
  end

  // lane c leaves the array c cycles after lane 0; delay it so every lane lands together
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int L = COLS - 1 - c;
    if (L == 0) begin : g_direct
      assign row[c*32 +: 32] = i_south[c*32 +: 32];
    end else begin : g_delay
      logic [31:0] dl [L];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < L; k++) begin
            dl[k] <= '0;
          end
        end else begin
          dl[0] <= i_south[c*32 +: 32];
          for (int k = 1; k < L; k++) begin
            dl[k] <= dl[k-1];
          end
        end
      end
      assign row[c*32 +: 32] = dl[L-1];
    end
  end

  assign o_valid    = (o_count != '0);
  assign push       = v[N];
  assign pop        = o_valid && i_ready;
  assign accept     = push && ((o_count != CW'(DEPTH)) || pop);
  assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_next = o_count + CW'(accept) - CW'(pop);
  assign o_busy     = (|v) || o_valid;

  // the pushed row becomes the head when nothing else survives this edge
  always_comb begin
    head_next = mem[rd_next];
    if (accept && (o_count == CW'(pop))) begin
      head_next = row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem[wr_ptr] <= row;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_data     <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      o_count <= count_next;
      if (push && !accept) begin
        o_overflow <= 1'b1;
      end
      if (count_next != '0) begin
        o_data <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - randomized and directed bench for systolic_drain against a queue-based row model
module tb_systolic_drain;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DEPTH = 8;
  localparam int N     = ROWS + COLS - 1;
  localparam int W     = COLS * 32;
  localparam int HMAX  = 4096;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   i_valid;
  logic [W-1:0]           i_south;
  logic                   o_valid;
  logic                   i_ready;
  logic [W-1:0]           o_data;
  logic                   o_overflow;
  logic                   o_busy;
  logic [$clog2(DEPTH):0] o_count;

  always #5 clk = ~clk;

  systolic_drain #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_south    (i_south),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_count    (o_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference: input history per cycle plus a queue of rows awaiting the consumer
  bit           vh [HMAX];
  logic [W-1:0] sh [HMAX];
  logic [W-1:0] q [$];
  int           t         = 0;
  int           last_rst  = -1;
  bit           ovf       = 1'b0;
  bit           armed     = 1'b0;
  bit           data_zero = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit exp_busy();
    bit b = (q.size() != 0);
    for (int T = t - N; T < t; T++) begin
      if (T > last_rst && T >= 0 && vh[T]) b = 1'b1;
    end
    return b;
  endfunction

  task automatic model_edge(input bit v, input logic [W-1:0] s, input bit r, input bit rn);
    int T;
    bit pop;
    logic [W-1:0] rw;
    if (t >= HMAX) begin
      $display("FAIL history_bound: got %0d expected below %0d", t, HMAX);
      $fatal(1, "history exhausted");
    end
    vh[t] = v && rn;
    sh[t] = s;
    if (!rn) begin
      q.delete();
      ovf       = 1'b0;
      last_rst  = t;
      data_zero = 1'b1;
      armed     = 1'b1;
    end else begin
      pop = (q.size() != 0) && r;
      T   = t - N;
      if (pop) void'(q.pop_front());
      if (T > last_rst && vh[T]) begin
        for (int c = 0; c < COLS; c++) begin
          rw[c*32 +: 32] = sh[T + ROWS + c][c*32 +: 32];
        end
        if (q.size() < DEPTH) begin
          q.push_back(rw);
          data_zero = 1'b0;
        end else begin
          ovf = 1'b1;
        end
      end
    end
    t++;
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] s, input bit r, input bit rn);
    reset   = rn;
    i_valid = v;
    i_south = s;
    i_ready = r;
    @(negedge clk);
    if (armed) begin
      check("o_valid", W'(o_valid), W'(q.size() != 0));
      check("o_count", W'(o_count), W'(q.size()));
      check("o_overflow", W'(o_overflow), W'(ovf));
      check("o_busy", W'(o_busy), W'(exp_busy()));
      if (q.size() != 0) check("o_data", o_data, q[0]);
      else if (data_zero) check("o_data_zero", o_data, '0);
    end
    @(posedge clk);
    model_edge(v, s, r, rn);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    cycle(1'b0, rnd(), 1'b1, 1'b0);
    cycle(1'b0, rnd(), 1'b1, 1'b0);
  endtask

  logic [W-1:0] s;
  logic [W-1:0] e;
  int popped;

  initial begin
    do_reset();

    // single vector, skewed lanes, filler elsewhere
    for (int k = 0; k <= 12; k++) begin
      for (int c = 0; c < COLS; c++) s[c*32 +: 32] = (k == ROWS + c) ? 32'h100 + c : 32'hDEAD;
      cycle(k == 0, s, 1'b1, 1'b1);
      if (k == 6) check("s1_early", W'(o_valid), W'(0));
      if (k == 7) begin
        check("s1_valid", W'(o_valid), W'(1));
        check("s1_row", o_data, {32'h103, 32'h102, 32'h101, 32'h100});
      end
      if (k == 8) begin
        check("s1_single", W'(o_valid), W'(0));
        check("s1_busy", W'(o_busy), W'(0));
      end
    end

    // back-to-back vectors
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      for (int c = 0; c < COLS; c++) s[c*32 +: 32] = k * 16 + c;
      cycle(k < 8, s, 1'b1, 1'b1);
      if (k >= 7 && k <= 14) begin
        for (int c = 0; c < COLS; c++) e[c*32 +: 32] = (k - 7 + 4 + c) * 16 + c;
        check("b2b_valid", W'(o_valid), W'(1));
        check("b2b_row", o_data, e);
      end
      if (k == 15) check("b2b_end", W'(o_valid), W'(0));
    end

    // backpressure into overflow, then drain
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      cycle(k < 10, rnd(), 1'b0, 1'b1);
      if (k == 14) check("bp_ovf_pre", W'(o_overflow), W'(0));
      if (k == 15) check("bp_ovf_set", W'(o_overflow), W'(1));
    end
    check("bp_count", W'(o_count), W'(8));
    check("bp_ovf", W'(o_overflow), W'(1));
    popped = 0;
    for (int j = 0; j < 12; j++) begin
      if (o_valid) popped++;
      cycle(1'b0, rnd(), 1'b1, 1'b1);
    end
    check("bp_drained", W'(popped), W'(8));

    // full FIFO with a pop in the push cycle
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      cycle((k < 8) || (k == 9), rnd(), k == 16, 1'b1);
      if (k == 15) check("full_pre", W'(o_count), W'(8));
    end
    check("full_count", W'(o_count), W'(8));
    check("full_ovf", W'(o_overflow), W'(0));
    for (int j = 0; j < 12; j++) cycle(1'b0, rnd(), 1'b1, 1'b1);

    // reset while a vector is in flight
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      cycle((k == 0) || (k == 21), rnd(), 1'b1, k != 3);
      if (k <= 20) check("rst_no_valid", W'(o_valid), W'(0));
      if (k == 3) begin
        check("rst_busy", W'(o_busy), W'(0));
        check("rst_count", W'(o_count), W'(0));
        check("rst_ovf", W'(o_overflow), W'(0));
        check("rst_data", o_data, '0);
      end
      if (k == 27) check("rst_new_early", W'(o_valid), W'(0));
      if (k == 28) check("rst_new_valid", W'(o_valid), W'(1));
    end

    // sign bits and extremes pass untouched
    do_reset();
    s = {32'h7FFFFFFF, 32'hFFFFFF80, 32'h7FFFFFFF, 32'hFFFFFF80};
    for (int k = 0; k <= 10; k++) begin
      cycle(k == 0, s, 1'b1, 1'b1);
      if (k == 7) check("signed_row", o_data, s);
    end

    // random traffic with bursts of backpressure and occasional resets
    do_reset();
    for (int j = 0; j < 400; j++) begin
      cycle($urandom_range(0, 1) == 1, rnd(),
            ((j % 100) < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 199) != 0);
    end
    for (int j = 0; j < 20; j++) cycle(1'b0, rnd(), 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
